// File: rtl/core_id_issue.sv
// Decode/issue stage: single-entry issue register, register-file read control and load scoreboard.
// Optional stall counter enabled by defining CORE_ID_STALL_CNT_EN.
module core_id_issue #(
    parameter int unsigned MAX_OUTSTANDING_LD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_re1,
    output logic        o_re2,
    output logic [4:0]  o_raddr1,
    output logic [4:0]  o_raddr2,
    output logic        o_rd_latch,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rd,
    output logic        o_rd_we,
    output logic        o_is_load,
    output logic        o_illegal,
    input  logic        i_ld_done,
    input  logic [4:0]  i_ld_rd,
    input  logic        i_flush,
    output logic [31:0] o_stall_cycles
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [2:0] MaxLd    = 3'(MAX_OUTSTANDING_LD);

    logic        held_valid_q;
    logic [31:0] instr_q, pc_q;
    logic [4:0]  rd_q;
    logic        rd_we_q, is_load_q, illegal_q;
    logic [31:1] pend_q, pend_d;
    logic [2:0]  ld_cnt_q, ld_cnt_d;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic        re1, re2;
    logic [31:0] clr_oh, set_oh, busy_vec;
    logic        hazard, ld_blocked, valid_out, handoff, ld_handoff, ready_out, accept;
    logic        dec_rd_we, dec_illegal;

    always_comb begin
        opcode = i_instr[6:0];
        rs1    = i_instr[19:15];
        rs2    = i_instr[24:20];
        re1    = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
        re2    = (opcode == OpBranch) || (opcode == OpStore) || (opcode == OpOp);

        dec_rd_we   = !(opcode == OpBranch || opcode == OpStore) && (i_instr[11:7] != 5'd0);
        dec_illegal = !(opcode inside {OpLui, OpAuipc, OpJal, OpJalr, OpBranch, OpLoad,
                                       OpStore, OpImm, OpOp});

        // A same-cycle writeback is captured by the register file, so it does not stall.
        clr_oh = '0;
        if (i_ld_done) clr_oh = 32'd1 << i_ld_rd;
        set_oh = 32'd1 << rd_q;

        busy_vec = {pend_q, 1'b0} & ~clr_oh;
        if (held_valid_q && is_load_q && rd_we_q) busy_vec = busy_vec | set_oh;
        busy_vec[0] = 1'b0;

        hazard = (re1 && busy_vec[rs1]) || (re2 && busy_vec[rs2]);

        ld_blocked = is_load_q && (ld_cnt_q == MaxLd) && !i_ld_done;
        valid_out  = held_valid_q && !ld_blocked;
        handoff    = valid_out && i_ready;
        ld_handoff = handoff && is_load_q && rd_we_q;
        ready_out  = (!held_valid_q || handoff) && !hazard && !i_flush;
        accept     = i_valid && ready_out;

        // Clear first so a new load to the same register wins.
        pend_d = pend_q & ~clr_oh[31:1];
        if (ld_handoff) pend_d = pend_d | set_oh[31:1];

        ld_cnt_d = ld_cnt_q;
        case ({ld_handoff, i_ld_done})
            2'b10:   ld_cnt_d = ld_cnt_q + 3'd1;
            2'b01:   if (ld_cnt_q != 3'd0) ld_cnt_d = ld_cnt_q - 3'd1;
            default: ld_cnt_d = ld_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid_q <= 1'b0;
            instr_q      <= 32'h0000_0013;
            pc_q         <= '0;
            rd_q         <= '0;
            rd_we_q      <= 1'b0;
            is_load_q    <= 1'b0;
            illegal_q    <= 1'b0;
            pend_q       <= '0;
            ld_cnt_q     <= '0;
        end else begin
            if (i_flush) begin
                held_valid_q <= 1'b0;
            end else if (accept) begin
                held_valid_q <= 1'b1;
                instr_q      <= i_instr;
                pc_q         <= i_pc;
                rd_q         <= i_instr[11:7];
                rd_we_q      <= dec_rd_we;
                is_load_q    <= (opcode == OpLoad);
                illegal_q    <= dec_illegal;
            end else if (handoff) begin
                held_valid_q <= 1'b0;
            end
            pend_q   <= pend_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end

`ifdef CORE_ID_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (i_valid && !ready_out && !i_flush) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign o_stall_cycles = stall_q;
`else
    assign o_stall_cycles = '0;
`endif

    assign o_ready    = ready_out;
    assign o_re1      = re1;
    assign o_re2      = re2;
    assign o_raddr1   = rs1;
    assign o_raddr2   = rs2;
    assign o_rd_latch = held_valid_q && !handoff;
    assign o_valid    = valid_out;
    assign o_instr    = instr_q;
    assign o_pc       = pc_q;
    assign o_rd       = rd_q;
    assign o_rd_we    = rd_we_q;
    assign o_is_load  = is_load_q;
    assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_core_id_issue.sv
// Scoreboard bench for core_id_issue: directed scenarios then randomized traffic against a
// reference model built from per-register pending flags and a queue of in-flight loads.
module tb_core_id_issue;

    localparam int unsigned MaxLd = 2;
    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk, rst_n;
    logic        i_valid, o_ready, i_ready, o_valid;
    logic [31:0] i_instr, i_pc, o_instr, o_pc, o_stall_cycles;
    logic        o_re1, o_re2, o_rd_latch, o_rd_we, o_is_load, o_illegal;
    logic [4:0]  o_raddr1, o_raddr2, o_rd, i_ld_rd;
    logic        i_ld_done, i_flush;

    core_id_issue #(.MAX_OUTSTANDING_LD(MaxLd)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr), .i_pc(i_pc),
        .o_re1(o_re1), .o_re2(o_re2), .o_raddr1(o_raddr1), .o_raddr2(o_raddr2),
        .o_rd_latch(o_rd_latch), .o_valid(o_valid), .i_ready(i_ready),
        .o_instr(o_instr), .o_pc(o_pc), .o_rd(o_rd), .o_rd_we(o_rd_we),
        .o_is_load(o_is_load), .o_illegal(o_illegal),
        .i_ld_done(i_ld_done), .i_ld_rd(i_ld_rd), .i_flush(i_flush),
        .o_stall_cycles(o_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_load;
        logic        illegal;
    } exp_t;

    exp_t        exp_q[$];
    int          inflight[$];
    bit          m_pend[32];
    bit          m_held, m_held_isld, m_held_rdwe;
    int          m_held_rd;
    int unsigned stall_m;
    int          n_checks, n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic bit busy(input int rs, input bit dn, input int dn_rd);
        if (rs == 0) return 1'b0;
        if (m_pend[rs] && !(dn && dn_rd == rs)) return 1'b1;
        return m_held && m_held_isld && m_held_rdwe && m_held_rd == rs;
    endfunction

    function automatic bit legal_op(input logic [6:0] op);
        return op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67 || op == 7'h63 ||
               op == 7'h03 || op == 7'h23 || op == 7'h13 || op == 7'h33;
    endfunction

    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
    endfunction

    function automatic logic [31:0] enc_lw(input int rd, input int rs1);
        return (32'(rs1) << 15) | (32'h2 << 12) | (32'(rd) << 7) | 32'h03;
    endfunction

    // One clock cycle: drive, compare combinational outputs, then advance the model.
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit rdy, input bit fl, input bit dn, input int dn_rd);
        logic [6:0] op;
        bit re1, re2, cap, ev, ho, hz, er, acc;
        exp_t e;
        @(negedge clk);
        i_valid = v; i_instr = ins; i_pc = pc; i_ready = rdy; i_flush = fl;
        i_ld_done = dn; i_ld_rd = 5'(dn_rd);
        #1;
        op  = ins[6:0];
        re1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        re2 = (op == 7'h63 || op == 7'h23 || op == 7'h33);
        cap = m_held && m_held_isld && (inflight.size() == int'(MaxLd)) && !dn;
        ev  = m_held && !cap;
        ho  = ev && rdy;
        hz  = (re1 && busy(int'(ins[19:15]), dn, dn_rd)) ||
              (re2 && busy(int'(ins[24:20]), dn, dn_rd));
        er  = (!m_held || ho) && !hz && !fl;
        acc = v && er;
        chk("o_valid", 32'(o_valid), 32'(ev));
        chk("o_ready", 32'(o_ready), 32'(er));
        chk("o_re1", 32'(o_re1), 32'(re1));
        chk("o_re2", 32'(o_re2), 32'(re2));
        chk("o_raddr1", 32'(o_raddr1), 32'(ins[19:15]));
        chk("o_raddr2", 32'(o_raddr2), 32'(ins[24:20]));
        chk("o_rd_latch", 32'(o_rd_latch), 32'(m_held && !ho));
`ifdef CORE_ID_STALL_CNT_EN
        chk("o_stall_cycles", o_stall_cycles, 32'(stall_m));
`else
        chk("o_stall_cycles", o_stall_cycles, 32'd0);
`endif
        if (acc) begin
            e.instr   = ins;
            e.pc      = pc;
            e.rd      = ins[11:7];
            e.rd_we   = !(op == 7'h63 || op == 7'h23) && ins[11:7] != 5'd0;
            e.is_load = (op == 7'h03);
            e.illegal = !legal_op(op);
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (v && !er && !fl) stall_m++;
        if (dn) begin
            m_pend[dn_rd] = 1'b0;
            for (int i = 0; i < inflight.size(); i++) begin
                if (inflight[i] == dn_rd) begin
                    inflight.delete(i);
                    break;
                end
            end
        end
        if (ho && m_held_isld && m_held_rdwe) begin
            m_pend[m_held_rd] = 1'b1;
            inflight.push_back(m_held_rd);
        end
        if (fl) begin
            if (m_held && !ho) void'(exp_q.pop_front());
            m_held = 1'b0;
        end else if (acc) begin
            m_held      = 1'b1;
            m_held_isld = (op == 7'h03);
            m_held_rdwe = !(op == 7'h63 || op == 7'h23) && ins[11:7] != 5'd0;
            m_held_rd   = int'(ins[11:7]);
        end else if (ho) begin
            m_held = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_instr = Nop; i_pc = '0; i_ready = 1'b0;
        i_flush = 1'b0; i_ld_done = 1'b0; i_ld_rd = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst o_valid", 32'(o_valid), 32'd0);
        chk("rst o_instr", o_instr, 32'h0000_0013);
        chk("rst o_pc", o_pc, 32'd0);
        chk("rst o_rd", 32'(o_rd), 32'd0);
        chk("rst o_rd_we", 32'(o_rd_we), 32'd0);
        chk("rst o_is_load", 32'(o_is_load), 32'd0);
        chk("rst o_illegal", 32'(o_illegal), 32'd0);
        chk("rst o_rd_latch", 32'(o_rd_latch), 32'd0);
        chk("rst o_stall_cycles", o_stall_cycles, 32'd0);
        chk("rst o_ready", 32'(o_ready), 32'd1);
        m_held = 1'b0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        inflight.delete();
        exp_q.delete();
        stall_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0] ops [0:9];
        logic [6:0] op;
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        op = ops[$urandom_range(0, 9)];
        w = $urandom;
        w[6:0]   = op;
        w[11:7]  = (op == 7'h03) ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic rand_cycles(input int n);
        bit dn;
        int dn_rd;
        for (int c = 0; c < n; c++) begin
            dn = 1'b0;
            dn_rd = $urandom_range(0, 31);
            if (inflight.size() > 0 && $urandom_range(0, 9) < 3) begin
                dn = 1'b1;
                dn_rd = inflight[$urandom_range(0, inflight.size() - 1)];
            end
            step($urandom_range(0, 9) < 8, gen_instr(), $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, dn, dn_rd);
        end
    endtask

    task automatic drain();
        while (inflight.size() > 0) step(1'b0, Nop, 32'd0, 1'b1, 1'b0, 1'b1, inflight[0]);
        step(1'b0, Nop, 32'd0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, Nop, 32'd0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    // Monitor: every handoff must match the oldest accepted instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL handoff at %0t: got instr 0x%08h, expected no handoff",
                             $time, o_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("o_instr", o_instr, e.instr);
                    chk("o_pc", o_pc, e.pc);
                    chk("o_rd", 32'(o_rd), 32'(e.rd));
                    chk("o_rd_we", 32'(o_rd_we), 32'(e.rd_we));
                    chk("o_is_load", 32'(o_is_load), 32'(e.is_load));
                    chk("o_illegal", 32'(o_illegal), 32'(e.illegal));
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b1;
        idle_inputs();
        apply_reset();

        // add x3,x1,x2 then handoff
        step(1'b1, 32'h0020_81B3, 32'h100, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, Nop, 32'd0, 1'b1, 1'b0, 1'b0, 0);

        // Load-use: add blocked by held lw, then by pend[5], accepted on writeback
        step(1'b1, enc_lw(5, 1), 32'h104, 1'b1, 1'b0, 1'b0, 0);
        repeat (4) step(1'b1, enc_r(6, 5, 0), 32'h108, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, enc_r(6, 5, 0), 32'h108, 1'b1, 1'b0, 1'b1, 5);
        step(1'b0, Nop, 32'd0, 1'b1, 1'b0, 1'b0, 0);

        // Execute stalls three cycles with add held
        step(1'b1, enc_r(3, 1, 2), 32'h200, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) step(1'b1, enc_r(4, 1, 2), 32'h204, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, enc_r(4, 1, 2), 32'h204, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, Nop, 32'd0, 1'b1, 1'b0, 1'b0, 0);

        // Outstanding-load cap: third load waits for a writeback
        step(1'b1, enc_lw(1, 0), 32'h300, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, enc_lw(2, 0), 32'h304, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, enc_lw(3, 0), 32'h308, 1'b1, 1'b0, 1'b0, 0);
        repeat (2) step(1'b0, Nop, 32'd0, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, Nop, 32'd0, 1'b1, 1'b0, 1'b1, 1);
        drain();

        // Flush a held lw x7; a dependent add must then issue freely
        step(1'b1, enc_lw(7, 0), 32'h400, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, Nop, 32'd0, 1'b0, 1'b1, 1'b0, 0);
        step(1'b1, enc_r(8, 7, 0), 32'h404, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, Nop, 32'd0, 1'b1, 1'b0, 1'b0, 0);

        // Unsupported opcode
        step(1'b1, 32'h0000_007F, 32'h500, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, Nop, 32'd0, 1'b1, 1'b0, 1'b0, 0);

        // Four-cycle hazard stall
        step(1'b1, enc_lw(5, 0), 32'h600, 1'b1, 1'b0, 1'b0, 0);
        repeat (4) step(1'b1, enc_r(6, 5, 0), 32'h604, 1'b1, 1'b0, 1'b0, 0);
        step(1'b1, enc_r(6, 5, 0), 32'h604, 1'b1, 1'b0, 1'b1, 5);
        drain();

        rand_cycles(1500);
        apply_reset();
        rand_cycles(1500);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/core_id_issue.md
# core_id_issue

Decode/issue stage directly upstream of the core register file. It accepts instructions from fetch, extracts rs1/rs2/rd and drives the register-file read ports. It holds each instruction in a single issue register until the execute stage takes it, and asserts the read-latch while execute stalls. A load scoreboard with an outstanding-load counter stalls load-use hazards.

## Interface
Parameters:
- MAX_OUTSTANDING_LD, default 2: maximum loads in flight between handoff and load writeback. Legal range 1..7.

Ports (clock `clk`; reset `rst_n`, asynchronous, active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  fetch has an instruction
- o_ready  out  1  issue stage accepts this cycle
- i_instr  in  32  instruction word
- i_pc  in  32  instruction PC
- o_re1 / o_re2  out  1  register-file read enables
- o_raddr1 / o_raddr2  out  5  register-file read addresses
- o_rd_latch  out  1  register file holds its read data
- o_valid  out  1  issued instruction available to execute
- i_ready  in  1  execute accepts
- o_instr  out  32  held instruction
- o_pc  out  32  held PC
- o_rd  out  5  destination register
- o_rd_we  out  1  destination write enable
- o_is_load  out  1  held instruction is a LOAD
- o_illegal  out  1  held opcode is unsupported
- i_ld_done  in  1  load writeback this cycle; same cycle as the register-file write
- i_ld_rd  in  5  register written by that load
- i_flush  in  1  redirect; kill the held instruction
- o_stall_cycles  out  32  stall counter (see Configuration)

## Operation
- Decode is combinational from i_instr, using opcode bits [6:0]:
  - o_re1 = 0 for LUI (0110111), AUIPC (0010111) and JAL (1101111); 1 otherwise.
  - o_re2 = 1 for BRANCH (1100011), STORE (0100011) and OP (0110011); 0 otherwise.
  - o_raddr1 = i_instr[19:15]; o_raddr2 = i_instr[24:20].
- Held fields are registered on accept:
  - rd_we = opcode not BRANCH/STORE, and rd != 0.
  - illegal = opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM 0010011, OP}.
- Scoreboard `pend[31:1]`:
  - Bit rd is set on a load handoff (o_valid & i_ready & o_is_load & o_rd_we).
  - Bit i_ld_rd is cleared on i_ld_done.
  - Set and clear of the same bit in one cycle leaves it set, because the new load wins.
- Hazard: an enabled source rs != 0 matches either of:
  - (pend & ~clr), where clr is the i_ld_done one-hot. A same-cycle clear does not stall, because the register file captures the write-port data.
  - The held instruction, when it is a load with o_rd_we and o_rd == rs.
- Outstanding counter `ld_cnt`, 3 bits:
  - +1 on load handoff, −1 on i_ld_done; simultaneous events leave it unchanged.
  - A held load presents o_valid = 0 while ld_cnt == MAX_OUTSTANDING_LD & ~i_ld_done.
- o_ready = (~held_valid | (o_valid & i_ready)) & ~hazard & ~i_flush.
- Accept = i_valid & o_ready: load the held registers and set held_valid.
- Handoff without accept clears held_valid.
- o_rd_latch = held_valid & ~(o_valid & i_ready).
- i_flush: held_valid clears at the next edge. pend and ld_cnt are unaffected, because handed-off loads still complete.

## Timing
- Reset values:
  - o_valid 0, o_instr 0x00000013, o_pc 0, o_rd 0, o_rd_we 0, o_is_load 0, o_illegal 0.
  - pend 0, ld_cnt 0, o_stall_cycles 0, o_rd_latch 0.
- Reset asserted mid-operation discards the held instruction and the scoreboard.
- Latency: accept at edge N → o_valid and the register-file data valid in cycle N+1.
- Throughput: one instruction per cycle with no hazard and i_ready = 1.
- o_ready depends combinationally on i_instr, i_ready, i_ld_done and i_flush; it has no dependency on o_ready itself.
- i_ld_done with ld_cnt == 0 is a protocol error. The counter saturates at 0.

## Configuration
- `CORE_ID_STALL_CNT_EN` defined: o_stall_cycles increments, wrapping, each cycle with i_valid & ~o_ready & ~i_flush.
- Not defined: o_stall_cycles is tied to 0 and no counter flops are built.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with i_ready = 1:
  - Accept cycle: o_re1 = o_re2 = 1, raddr 1/2.
  - Next cycle: o_valid = 1, o_rd = 3, o_rd_we = 1.
- `lw x5,0(x1)` then `add x6,x5,x0`:
  - The add is blocked (o_ready = 0) while the lw is held and while pend[5] = 1.
  - The add is accepted in the cycle i_ld_done = 1 with i_ld_rd = 5.
- i_ready = 0 for 3 cycles with `add` held:
  - o_rd_latch = 1 for those 3 cycles; o_ready = 0.
  - Handoff on the 4th cycle.
- MAX_OUTSTANDING_LD = 2, three independent loads, no i_ld_done:
  - Third load is held with o_valid = 0.
  - It releases the cycle i_ld_done arrives; ld_cnt stays 2.
- i_flush with a held load x7: o_valid = 0 next cycle; pend[7] = 0; ld_cnt unchanged.
- Opcode 0x7F: o_illegal = 1. With `CORE_ID_STALL_CNT_EN`, a 4-cycle hazard stall gives o_stall_cycles = 4.
